// File: rtl/tm_sched_pkg.sv
// tm_sched_pkg: shared sizes and types for the truncated-multiplier round-robin scheduler
package tm_sched_pkg;
   localparam int NREQ = 4;
   localparam int OPW = 8;
   localparam int PW = 16;
   typedef logic [$clog2(NREQ)-1:0] id_t;
   typedef logic [2:0] k_t;
endpackage

// File: rtl/u_tm8_rr_sched_if.sv
// u_tm8_rr_sched_if: request, response and config signals of the scheduler
interface u_tm8_rr_sched_if;
   import tm_sched_pkg::*;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ*OPW-1:0] req_a;
   logic [NREQ*OPW-1:0] req_b;
   logic resp_valid;
   logic resp_ready;
   id_t resp_id;
   logic [PW-1:0] resp_p;
   logic cfg_we;
   k_t cfg_k;
   logic cfg_err;
   logic busy;
   modport master (
      output req_valid, req_a, req_b, resp_ready, cfg_we, cfg_k,
      input req_ready, resp_valid, resp_id, resp_p, cfg_err, busy
   );
   modport slave (
      input req_valid, req_a, req_b, resp_ready, cfg_we, cfg_k,
      output req_ready, resp_valid, resp_id, resp_p, cfg_err, busy
   );
endinterface

// File: rtl/u_tm8_rr_sched_mul.sv
// tm8_mul_k: 8x8 multiplier that drops operand bits below position k
module tm8_mul_k
   import tm_sched_pkg::*;
(
   input logic [OPW-1:0] a,
   input logic [OPW-1:0] b,
   input k_t k,
   output logic [PW-1:0] p
);
   logic [OPW-1:0] m;
   // keeping only a_i, b_j with i,j >= k is the same as masking both operands
   assign m = {OPW{1'b1}} << k;
   assign p = PW'(a & m) * PW'(b & m);
endmodule

// File: rtl/u_tm8_rr_sched.sv
// u_tm8_rr_sched: round-robin arbiter feeding a 2-stage truncated multiplier pipeline
module u_tm8_rr_sched #(
   parameter int NREQ = tm_sched_pkg::NREQ,
   parameter tm_sched_pkg::k_t K_RST = 3'd7
) (
   input logic clk,
   input logic rst,
   u_tm8_rr_sched_if.slave bus
);
   import tm_sched_pkg::*;
   logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, cfg_err_q, cfg_err_d;
   logic [OPW-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   id_t s1_id_q, s1_id_d, s2_id_q, s2_id_d, ptr_q, ptr_d, gnt_id;
   k_t s1_k_q, s1_k_d, k_q, k_d;
   logic [PW-1:0] s2_p_q, s2_p_d, mul_p;
   logic gnt_v, s2_load, s1_load, xfer, wr_ok, busy;
   always_comb begin
      gnt_v = 1'b0;
      gnt_id = ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (!gnt_v && bus.req_valid[ptr_q + id_t'(i)]) begin
            gnt_v = 1'b1;
            gnt_id = ptr_q + id_t'(i);
         end
      end
   end
   assign busy = s1_v_q || s2_v_q;
   assign s2_load = !s2_v_q || bus.resp_ready;
   assign s1_load = !s1_v_q || s2_load;
   assign xfer = gnt_v && s1_load && !rst;
   // a write colliding with an accept loses, so the accepted request keeps the old K
   assign wr_ok = bus.cfg_we && !busy && !xfer;
   tm8_mul_k u_mul (.a(s1_a_q), .b(s1_b_q), .k(s1_k_q), .p(mul_p));
   always_comb begin
      s1_v_d = xfer || (s1_v_q && !s2_load);
      s1_a_d = xfer ? bus.req_a[OPW*gnt_id +: OPW] : s1_a_q;
      s1_b_d = xfer ? bus.req_b[OPW*gnt_id +: OPW] : s1_b_q;
      s1_id_d = xfer ? gnt_id : s1_id_q;
      s1_k_d = xfer ? k_q : s1_k_q;
      ptr_d = xfer ? gnt_id + id_t'(1) : ptr_q;
      s2_v_d = s2_load ? s1_v_q : s2_v_q;
      s2_id_d = (s2_load && s1_v_q) ? s1_id_q : s2_id_q;
      s2_p_d = (s2_load && s1_v_q) ? mul_p : s2_p_q;
      k_d = wr_ok ? bus.cfg_k : k_q;
      cfg_err_d = bus.cfg_we && !wr_ok;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q <= 1'b0;
         s1_a_q <= '0;
         s1_b_q <= '0;
         s1_id_q <= '0;
         s1_k_q <= '0;
         s2_v_q <= 1'b0;
         s2_id_q <= '0;
         s2_p_q <= '0;
         ptr_q <= '0;
         k_q <= K_RST;
         cfg_err_q <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         s1_a_q <= s1_a_d;
         s1_b_q <= s1_b_d;
         s1_id_q <= s1_id_d;
         s1_k_q <= s1_k_d;
         s2_v_q <= s2_v_d;
         s2_id_q <= s2_id_d;
         s2_p_q <= s2_p_d;
         ptr_q <= ptr_d;
         k_q <= k_d;
         cfg_err_q <= cfg_err_d;
      end
   end
   assign bus.req_ready = xfer ? NREQ'(1) << gnt_id : '0;
   assign bus.resp_valid = s2_v_q;
   assign bus.resp_id = s2_id_q;
   assign bus.resp_p = s2_p_q;
   assign bus.cfg_err = cfg_err_q;
   assign bus.busy = busy;
endmodule

// File: tb/tb_u_tm8_rr_sched.sv
// tb_u_tm8_rr_sched: vector table plus corner sequences, checked against a cycle model and result queue
module tb_u_tm8_rr_sched;
   import tm_sched_pkg::*;
   typedef struct packed {logic [1:0] id; logic [15:0] p;} exp_t;
   typedef struct packed {logic wr; logic [2:0] k; logic [1:0] id; logic [7:0] a; logic [7:0] b; logic [15:0] p;} vec_t;
   logic clk = 1'b0;
   logic rst;
   int n_cmp = 0;
   int n_bad = 0;
   u_tm8_rr_sched_if bus();
   u_tm8_rr_sched #(.NREQ(4), .K_RST(3'd7)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic [2:0] k);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (i >= int'(k) && j >= int'(k) && a[i] && b[j]) p += 16'(1) << (i + j);
      return p;
   endfunction
   // cycle model: two stage-occupancy flags, ptr, K and the pending-result queue
   logic m1, m2, err_m;
   logic [2:0] k_m;
   logic [1:0] ptr_m;
   exp_t sb[$];
   logic [1:0] gl[$];
   logic [1:0] rl[$];
   always @(negedge clk) begin : mon
      logic gv, s2l, can, xf, wr_ok;
      logic [1:0] g, c;
      logic [3:0] er;
      exp_t e;
      if (rst) begin
         m1 <= 1'b0;
         m2 <= 1'b0;
         err_m <= 1'b0;
         k_m <= 3'd7;
         ptr_m <= 2'd0;
         sb.delete();
      end else begin
         gv = 1'b0;
         g = 2'd0;
         for (int i = 0; i < 4; i++) begin
            c = ptr_m + 2'(i);
            if (!gv && bus.req_valid[c]) begin
               gv = 1'b1;
               g = c;
            end
         end
         s2l = !m2 || bus.resp_ready;
         can = !m1 || s2l;
         xf = gv && can;
         er = xf ? 4'b1 << g : 4'b0;
         check("req_ready", 32'(bus.req_ready), 32'(er));
         check("busy", 32'(bus.busy), 32'(m1 || m2));
         check("cfg_err", 32'(bus.cfg_err), 32'(err_m));
         check("resp_valid", 32'(bus.resp_valid), 32'(m2));
         if (m2) begin
            e = sb[0];
            check("resp_id", 32'(bus.resp_id), 32'(e.id));
            check("resp_p", 32'(bus.resp_p), 32'(e.p));
            if (bus.resp_ready) begin
               void'(sb.pop_front());
               rl.push_back(e.id);
            end
         end
         if (xf) begin
            sb.push_back({g, ref_mul(bus.req_a[8*g +: 8], bus.req_b[8*g +: 8], k_m)});
            gl.push_back(g);
            ptr_m <= g + 2'd1;
         end
         wr_ok = bus.cfg_we && !m1 && !m2 && !xf;
         err_m <= bus.cfg_we && !wr_ok;
         if (wr_ok) k_m <= bus.cfg_k;
         m2 <= s2l ? m1 : m2;
         m1 <= xf || (m1 && !s2l);
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_idle;
      int n = 0;
      while (bus.busy && n < 50) begin
         tick;
         n++;
      end
      check("idle_timeout", 32'(bus.busy), 32'(0));
   endtask
   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask
   task automatic set_k(input logic [2:0] k);
      bus.cfg_we = 1'b1;
      bus.cfg_k = k;
      tick;
      bus.cfg_we = 1'b0;
      check("set_k_err", 32'(bus.cfg_err), 32'(0));
   endtask
   task automatic send_chk(input string name, input logic [1:0] id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
      bus.req_a = $urandom;
      bus.req_b = $urandom;
      bus.req_a[8*id +: 8] = a;
      bus.req_b[8*id +: 8] = b;
      bus.req_valid = 4'b1 << id;
      #1;
      check({name, "_ready"}, 32'(bus.req_ready), 32'(4'b1 << id));
      tick;
      bus.req_valid = '0;
      tick;
      check({name, "_valid"}, 32'(bus.resp_valid), 32'(1));
      check({name, "_p"}, 32'(bus.resp_p), 32'(p));
      check({name, "_id"}, 32'(bus.resp_id), 32'(id));
      tick;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t tv[9];
      int bg, br;
      tv[0] = {1'b0, 3'd7, 2'd0, 8'hFF, 8'hFF, 16'h4000};
      tv[1] = {1'b0, 3'd7, 2'd1, 8'h7F, 8'hFF, 16'h0000};
      tv[2] = {1'b1, 3'd0, 2'd0, 8'hFF, 8'hFF, 16'hFE01};
      tv[3] = {1'b1, 3'd0, 2'd3, 8'h12, 8'h34, 16'h03A8};
      tv[4] = {1'b1, 3'd1, 2'd1, 8'h03, 8'h03, 16'h0004};
      tv[5] = {1'b1, 3'd2, 2'd2, 8'hFF, 8'h0F, 16'h0BD0};
      tv[6] = {1'b1, 3'd3, 2'd3, 8'hAA, 8'h55, 16'h3480};
      tv[7] = {1'b1, 3'd4, 2'd2, 8'hFF, 8'hFF, 16'hE100};
      tv[8] = {1'b1, 3'd0, 2'd0, 8'h00, 8'hFF, 16'h0000};
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.resp_ready = 1'b1;
      bus.cfg_we = 1'b0;
      bus.cfg_k = '0;
      tick;
      tick;
      check("rst_req_ready", 32'(bus.req_ready), 32'(0));
      check("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
      check("rst_resp_id", 32'(bus.resp_id), 32'(0));
      check("rst_resp_p", 32'(bus.resp_p), 32'(0));
      check("rst_cfg_err", 32'(bus.cfg_err), 32'(0));
      check("rst_busy", 32'(bus.busy), 32'(0));
      rst = 1'b0;
      tick;
      for (int t = 0; t < 9; t++) begin
         if (tv[t].wr) set_k(tv[t].k);
         send_chk("vec", tv[t].id, tv[t].a, tv[t].b, tv[t].p);
      end
      // all requesters held valid: grants and responses rotate 0,1,2,3,0
      do_reset;
      bg = gl.size();
      br = rl.size();
      bus.req_a = 32'h44332211;
      bus.req_b = 32'hF0E0D0C0;
      bus.req_valid = 4'hF;
      repeat (5) tick;
      bus.req_valid = '0;
      wait_idle;
      tick;
      check("rr_grants", 32'(gl.size() - bg), 32'(5));
      check("rr_resps", 32'(rl.size() - br), 32'(5));
      for (int i = 0; i < 5; i++) begin
         check("rr_grant_order", 32'(gl[bg+i]), 32'(i % 4));
         check("rr_resp_order", 32'(rl[br+i]), 32'(i % 4));
      end
      // backpressure: two accepts then all ready low, drain on release
      bg = gl.size();
      br = rl.size();
      bus.resp_ready = 1'b0;
      bus.req_valid = 4'hF;
      repeat (5) tick;
      check("stall_accepts", 32'(gl.size() - bg), 32'(2));
      check("stall_ready", 32'(bus.req_ready), 32'(0));
      check("stall_valid", 32'(bus.resp_valid), 32'(1));
      bus.req_valid = '0;
      bus.resp_ready = 1'b1;
      wait_idle;
      tick;
      check("stall_drained", 32'(rl.size() - br), 32'(2));
      // config write while busy is rejected, retried when idle
      do_reset;
      bus.req_a = 32'h000000FF;
      bus.req_b = 32'h000000FF;
      bus.req_valid = 4'b0001;
      tick;
      bus.req_valid = '0;
      bus.cfg_we = 1'b1;
      bus.cfg_k = 3'd4;
      tick;
      bus.cfg_we = 1'b0;
      check("busy_wr_err", 32'(bus.cfg_err), 32'(1));
      tick;
      check("busy_wr_err_pulse", 32'(bus.cfg_err), 32'(0));
      check("busy_wr_old_k_p", 32'(bus.resp_p), 32'(16'h4000));
      wait_idle;
      tick;
      set_k(3'd4);
      send_chk("k4", 2'd0, 8'hFF, 8'hFF, 16'hE100);
      // write colliding with an accept: request uses the old K, write rejected
      bus.req_a = 32'h00FF0000;
      bus.req_b = 32'h00FF0000;
      bus.req_valid = 4'b0100;
      bus.cfg_we = 1'b1;
      bus.cfg_k = 3'd0;
      tick;
      bus.req_valid = '0;
      bus.cfg_we = 1'b0;
      check("coll_err", 32'(bus.cfg_err), 32'(1));
      tick;
      check("coll_p", 32'(bus.resp_p), 32'(16'hE100));
      check("coll_id", 32'(bus.resp_id), 32'(2));
      tick;
      send_chk("coll_k_kept", 2'd1, 8'hFF, 8'hFF, 16'hE100);
      // reset with two transactions in flight
      bus.resp_ready = 1'b0;
      bus.req_a = 32'h11223344;
      bus.req_b = 32'h55667788;
      bus.req_valid = 4'hF;
      repeat (3) tick;
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'(0));
      check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'(0));
      check("mid_rst_resp_id", 32'(bus.resp_id), 32'(0));
      check("mid_rst_resp_p", 32'(bus.resp_p), 32'(0));
      check("mid_rst_cfg_err", 32'(bus.cfg_err), 32'(0));
      check("mid_rst_busy", 32'(bus.busy), 32'(0));
      bus.req_valid = '0;
      bus.resp_ready = 1'b1;
      tick;
      rst = 1'b0;
      repeat (4) begin
         tick;
         check("post_rst_quiet", 32'(bus.resp_valid), 32'(0));
      end
      send_chk("post_rst", 2'd0, 8'hFF, 8'hFF, 16'h4000);
      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/u_tm8_rr_sched.md
U_TM8_RR_SCHED -- requirements
Module: u_tm8_rr_sched

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter: K_RST, 7, truncation level loaded into the K register at reset.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: req_valid in 4; req_ready out 4; req_a in 32 (requester i at bits 8i+7:8i); req_b in 32 (same packing).
REQ-006 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_id out 2 (index of the requester that was served); resp_p out 16 (product).
REQ-007 SHALL have ports: cfg_we in 1; cfg_k in 3; cfg_err out 1 (one-cycle pulse when a write is rejected); busy out 1.

Function
REQ-008 SHALL compute p = sum of a_i·b_j·2^(i+j) over i>=K and j>=K, where i and j run 0..7; K=0 gives the exact product, and K=7 gives a7·b7 at bit 14 with bit 15 = 0.
REQ-009 SHALL arbitrate round-robin: priority order is ptr, ptr+1, ... mod 4; ptr = 0 after reset; after a grant to i, ptr becomes (i+1) mod 4.
REQ-010 SHALL drive req_ready one-hot or zero: only the granted requester sees ready, and only when stage 1 can load; the transfer occurs when valid and ready are both high.
REQ-011 SHALL, on a transfer, register a, b, id and the current K in stage 1; the stage 1 outputs feed the multiplier.
REQ-012 SHALL load stage 2 (p, id) from stage 1 when stage 2 is empty or resp_ready=1.
REQ-013 SHALL define stage 1 as able to load when it is empty or when it advances into stage 2 in the same cycle.
REQ-014 SHALL have latency 2: a transfer at edge n gives resp_valid=1 after edge n+1; throughput is one result per cycle while resp_ready=1.
REQ-015 SHALL hold resp_valid, resp_id and resp_p stable until resp_ready=1; with resp_ready=0 it SHALL hold at most 2 outstanding transactions and deassert all req_ready.
REQ-016 SHALL drive busy = stage 1 valid OR stage 2 valid.
REQ-017 SHALL write cfg_k to the K register only when cfg_we=1, busy=0 and no transfer occurs that edge; otherwise the write is ignored and cfg_err pulses for one cycle.
REQ-018 SHALL, when a config write and a request arrive in the same cycle with busy=0, accept the request using the old K and reject the write.
REQ-019 SHALL keep the K used by each transaction fixed at its snapshot from acceptance.
REQ-020 SHALL ignore req_a and req_b for requesters that are not granted.

Reset
REQ-021 SHALL, on rst=1 (async), clear stage 1 and stage 2, set ptr=0 and K=K_RST, and set req_ready=0, resp_valid=0, resp_id=0, resp_p=0, cfg_err=0 and busy=0.
REQ-022 SHALL discard in-flight transactions on reset mid-operation; no response is produced for them after reset is released.

Structure
REQ-023 SHALL place NREQ, operand width 8, product width 16, and the id and K typedefs in the shared package tm_sched_pkg.
REQ-024 SHALL instantiate one combinational sub-module tm8_mul_k (inputs a, b, k; output p) that implements REQ-008 once and is shared by all requesters.

Verification
REQ-025 SHALL test: K=0; req0 sends a=0xFF, b=0xFF -> two cycles later resp_p=0xFE01, resp_id=0.
REQ-026 SHALL test: reset default K=7; a=0xFF, b=0xFF -> resp_p=0x4000; a=0x7F, b=0xFF -> resp_p=0x0000.
REQ-027 SHALL test: all four requesters held valid, resp_ready=1 -> grants in the order 0,1,2,3,0, one per cycle; resp_id follows the same order two cycles later.
REQ-028 SHALL test: resp_ready=0 for 5 cycles with all requesters valid -> exactly 2 accepts, then req_ready=0; resp_p stays stable; on release, the results drain in order with no loss.
REQ-029 SHALL test: cfg_we with cfg_k=4 while busy=1 -> cfg_err pulses and K is unchanged; the write retried when idle succeeds; a=0xFF, b=0xFF -> resp_p=0xE100.
REQ-030 SHALL test: rst asserted with 2 transactions in flight -> all outputs reach reset values immediately; no resp_valid appears after release until a new request is sent.
